// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 8-bit ALU between NUM_REQ requesters.
// One transaction in flight; illegal opcodes are answered with an error without touching the ALU.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   req_sel,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]     req_cin,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [7:0]             rsp_y,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [4:0]             alu_sel,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic                   alu_cin,
    input  logic [7:0]             alu_y
);

    typedef enum logic [1:0] {IDLE, RUN, REJ} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [ID_W-1:0]      win_q, win_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [7:0]           rsp_y_q, rsp_y_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;
    logic [4:0]           alu_sel_q, alu_sel_d;
    logic [7:0]           alu_a_q, alu_a_d;
    logic [7:0]           alu_b_q, alu_b_d;
    logic                 alu_cin_q, alu_cin_d;

    logic                 found;
    logic [ID_W-1:0]      pick;
    logic [4:0]           pick_sel;
    logic [7:0]           pick_a, pick_b;
    logic                 pick_cin;
    logic                 pick_legal;

    function automatic logic is_legal(input logic [4:0] s);
        return (s <= 5'd8) || (s == 5'd16) || (s == 5'd24);
    endfunction

    // Two passes give "first at or above rr_q", then wrap to the low indices.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (ID_W'(j) >= rr_q)) begin
                found = 1'b1;
                pick  = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = ID_W'(j);
            end
        end
    end

    always_comb begin
        pick_sel = '0;
        pick_a   = '0;
        pick_b   = '0;
        pick_cin = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == ID_W'(j)) begin
                pick_sel = req_sel[5*j +: 5];
                pick_a   = req_a[8*j +: 8];
                pick_b   = req_b[8*j +: 8];
                pick_cin = req_cin[j];
            end
        end
        pick_legal = is_legal(pick_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = pick_legal ? RUN : REJ;
            RUN:     if (cnt_q == 3'd0) state_d = IDLE;
            REJ:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        rr_d        = rr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d  = NUM_REQ'(1) << pick;
                    win_d  = pick;
                    busy_d = 1'b1;
                    cnt_d  = 3'(ALU_LAT);
                    // Rejected ops leave the ALU ports untouched.
                    if (pick_legal) begin
                        alu_sel_d = pick_sel;
                        alu_a_d   = pick_a;
                        alu_b_d   = pick_b;
                        alu_cin_d = pick_cin;
                    end
                end
            end
            RUN: begin
                if (cnt_q == 3'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = win_q;
                    rsp_y_d     = alu_y;
                    rsp_err_d   = 1'b0;
                    busy_d      = 1'b0;
                    rr_d        = (win_q == ID_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            REJ: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = win_q;
                rsp_y_d     = 8'h00;
                rsp_err_d   = 1'b1;
                busy_d      = 1'b0;
                rr_d        = (win_q == ID_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            rr_q        <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: pipelined ALU model on the alu_* ports, directed scenarios,
// then random traffic checked against a transaction-level round-robin model.
module tb_alu_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [5*N-1:0]   req_sel;
    logic [8*N-1:0]   req_a, req_b;
    logic [N-1:0]     req_cin;
    logic [N-1:0]     gnt;
    logic             rsp_valid, rsp_err, busy, alu_cin;
    logic [IDW-1:0]   rsp_id;
    logic [7:0]       rsp_y, alu_a, alu_b, alu_y;
    logic [4:0]       alu_sel;

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;
    logic [4:0] m_sel = '0;
    logic [7:0] m_a = '0, m_b = '0;
    logic m_cin = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .ID_W(IDW), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_a(req_a),
        .req_b(req_b), .req_cin(req_cin), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_y(alu_y)
    );

    function automatic logic [7:0] alu_fn(input logic [4:0] s, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        case (s)
            5'd0:    return 8'(a + b);
            5'd1:    return 8'(a + b + {7'b0, c});
            5'd2:    return 8'(a - b);
            5'd3:    return 8'(a - b - {7'b0, ~c});
            5'd4:    return a & b;
            5'd5:    return a | b;
            5'd6:    return a ^ b;
            5'd7:    return ~a;
            5'd8:    return a;
            5'd16:   return {a[6:0], 1'b0};
            5'd24:   return {1'b0, a[7:1]};
            default: return 8'h5A;
        endcase
    endfunction

    // External ALU: result appears LAT edges after operands are sampled.
    logic [7:0] y_pipe [LAT];
    always @(posedge clk) begin
        y_pipe[0] <= alu_fn(alu_sel, alu_a, alu_b, alu_cin);
        for (int k = 1; k < LAT; k++) y_pipe[k] <= y_pipe[k-1];
    end
    assign alu_y = y_pipe[LAT-1];

    function automatic bit legal_op(input logic [4:0] s);
        return s inside {[5'd0:5'd8], 5'd16, 5'd24};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [4:0] s, input logic [7:0] a,
                          input logic [7:0] b, input logic c);
        req_sel[5*i +: 5] = s;
        req_a[8*i +: 8]   = a;
        req_b[8*i +: 8]   = b;
        req_cin[i]        = c;
        req[i]            = 1'b1;
    endtask

    task automatic rand_op(input int i, input bit legal);
        logic [4:0] lst [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd16, 5'd24};
        logic [4:0] s;
        if (legal) s = lst[$urandom_range(0, 10)];
        else begin
            s = 5'($urandom);
            while (legal_op(s)) s = 5'($urandom);
        end
        set_op(i, s, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {gnt, rsp_valid, rsp_err, busy, alu_cin}, '0);
        chk({tag, "_data"}, {rsp_id, rsp_y, alu_sel}, '0);
        chk({tag, "_alu"}, {alu_a, alu_b}, '0);
    endtask

    // Waits for a grant, then checks the whole transaction to its response.
    task automatic txn(input bit keep, input int pulse, output int obs_w);
        int w, cyc, lat;
        logic [4:0] s;
        logic [7:0] a, b;
        logic c;
        bit lg;
        w = rr_pick(req, m_ptr);
        s = req_sel[5*w +: 5];
        a = req_a[8*w +: 8];
        b = req_b[8*w +: 8];
        c = req_cin[w];
        lg = legal_op(s);
        cyc = 0;
        do begin step(); cyc++; end while (gnt === '0 && cyc < 20);
        obs_w = onehot_idx(gnt);
        chk("gnt_latency", cyc, 1);
        chk("gnt_onehot", gnt, N'(1) << w);
        chk("busy_at_gnt", busy, 1'b1);
        if (lg) begin m_sel = s; m_a = a; m_b = b; m_cin = c; end
        chk("alu_ports", {alu_sel, alu_a, alu_b, alu_cin}, {m_sel, m_a, m_b, m_cin});
        if (!keep) req[w] = 1'b0;
        lat = lg ? LAT + 1 : 1;
        for (int k = 1; k < lat; k++) begin
            step();
            if (pulse >= 0 && k == 1) req[pulse] = 1'b1;
            if (pulse >= 0 && k == lat - 1 && k > 1) req[pulse] = 1'b0;
            chk("rsp_early", {rsp_valid, gnt}, '0);
            chk("busy_run", busy, 1'b1);
            chk("alu_stable", {alu_sel, alu_a, alu_b, alu_cin}, {m_sel, m_a, m_b, m_cin});
        end
        step();
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, w);
        chk("rsp_y", rsp_y, lg ? alu_fn(s, a, b, c) : 8'h00);
        chk("rsp_err", rsp_err, !lg);
        chk("busy_done", {busy, gnt}, '0);
        m_ptr = (w + 1) % N;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        m_sel = '0; m_a = '0; m_b = '0; m_cin = 1'b0;
    endtask

    initial begin
        int w, cyc;
        rst_n = 1'b0; req = '0; req_sel = '0; req_a = '0; req_b = '0; req_cin = '0;

        // 1: single legal op
        do_reset();
        repeat (2) step();
        chk_all_zero("idle");
        set_op(0, 5'b00001, 8'hF0, 8'h0F, 1'b1);
        txn(1'b0, -1, w);
        chk("t1_y", rsp_y, 8'h00);
        step();
        chk("t1_pulse", rsp_valid, 1'b0);

        // 2: all four requesting through reset
        for (int i = 0; i < N; i++) rand_op(i, 1'b1);
        do_reset();
        for (int i = 0; i < N; i++) begin
            txn(1'b0, -1, w);
            chk("t2_order", w, i);
        end

        // 3: two requesters held high alternate
        rand_op(1, 1'b1);
        rand_op(2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            txn(1'b1, -1, w);
            chk("t3_alt", w, (i % 2 == 0) ? 1 : 2);
        end
        req = '0;
        step();

        // 4: legal OR then illegal opcode
        set_op(2, 5'b00101, 8'hA5, 8'h18, 1'b0);
        txn(1'b0, -1, w);
        chk("t4_or", rsp_y, 8'hBD);
        set_op(2, 5'b01001, 8'h33, 8'h44, 1'b1);
        txn(1'b0, -1, w);
        chk("t4_sel_kept", alu_sel, 5'b00101);

        // 5: reset one cycle after gnt drops the transaction
        rand_op(0, 1'b1);
        step();
        chk("t5_gnt", gnt, 4'b0001);
        req = '0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        m_sel = '0; m_a = '0; m_b = '0; m_cin = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            step();
            chk("t5_no_rsp", {rsp_valid, busy, gnt}, '0);
        end
        rand_op(1, 1'b1);
        rand_op(3, 1'b1);
        txn(1'b0, -1, w);
        chk("t5_ptr0", w, 1);
        txn(1'b0, -1, w);

        // 6: req3 pulsed during RUN is withdrawn
        rand_op(0, 1'b1);
        req_sel[15 +: 5] = 5'd4;
        txn(1'b0, 3, w);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_quiet", {rsp_valid, gnt}, '0);
        end

        // random traffic against the round-robin model
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) rand_op(i, $urandom_range(0, 3) != 0);
            if (req == '0) rand_op($urandom_range(0, N - 1), 1'b1);
            txn($urandom_range(0, 3) == 0, -1, w);
        end
        req = '0;
        step();
        cyc = 0;
        repeat (3) begin step(); if (gnt !== '0) cyc++; end
        chk("drain_no_gnt", cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
